// File: rtl/if_ctrl_pkg.sv
// if_ctrl_pkg: widths, state encodings and the fetch queue entry layout
package if_ctrl_pkg;
  localparam int PC_WIDTH = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int IF_EXC_WIDTH = 2;
  localparam int IF_EXC_MISALIGN = 0;
  localparam int IF_EXC_BUSERR = 1;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);
  localparam logic [1:0] IFC_BOOT = 2'd0;
  localparam logic [1:0] IFC_RUN = 2'd1;
  localparam logic [1:0] IFC_HOLD = 2'd2;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [IF_EXC_WIDTH-1:0] exc;
  } if_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: 2-entry synchronous FIFO with push, pop and flush
module if_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign full = count == 2'(D);
  assign empty = count == 2'd0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  // pointers and occupancy; flush wins over any push or pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ do_push;
      rd_ptr <= rd_ptr ^ do_pop;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  // entry storage; contents are only observed through a nonempty head
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/if_ctrl.sv
// if_ctrl: program counter, fetch state machine and decode-facing fetch queue
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int QDEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [PC_WIDTH-1:0]     pc_o,
  input  logic [INSTR_WIDTH-1:0]  if_bus_instr_i,
  input  logic                    if_bus_pc_misalign_i,
  input  logic                    if_bus_bus_err_i,
  input  logic                    redirect_valid_i,
  input  logic [PC_WIDTH-1:0]     redirect_pc_i,
  input  logic                    trap_valid_i,
  input  logic [PC_WIDTH-1:0]     trap_pc_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [PC_WIDTH-1:0]     id_pc_o,
  output logic [INSTR_WIDTH-1:0]  id_instr_o,
  output logic [IF_EXC_WIDTH-1:0] id_exc_o
);
  logic [1:0] state, state_nx;
  logic [PC_WIDTH-1:0] pc_nx;
  logic [IF_EXC_WIDTH-1:0] exc;
  logic [1:0] count;
  logic flush, deq, fetch_fire, full, empty, fault;
  if_entry_t push_e, head_e, raw_e;
  assign flush = trap_valid_i | redirect_valid_i;
  assign deq = id_valid_o && id_ready_i;
  assign fetch_fire = state == IFC_RUN && !flush && (!full || deq);
  assign fault = |exc;
  assign push_e = '{pc: pc_o, instr: if_bus_instr_i, exc: exc};
  assign id_valid_o = !empty;
  assign head_e = empty ? '0 : raw_e;
  assign id_pc_o = head_e.pc;
  assign id_instr_o = head_e.instr;
  assign id_exc_o = head_e.exc;
  // fault flags for the word being fetched this cycle
  always_comb begin
    exc = '0;
    exc[IF_EXC_MISALIGN] = if_bus_pc_misalign_i | (pc_o[1:0] != 2'b00);
    exc[IF_EXC_BUSERR] = if_bus_bus_err_i;
  end
  // next PC and next state; a faulting fetch parks the PC on the faulting address
  always_comb begin
    pc_nx = flush ? (trap_valid_i ? trap_pc_i : redirect_pc_i) : (fetch_fire && !fault) ? pc_o + PC_STEP : pc_o;
    state_nx = (flush || state == IFC_BOOT) ? IFC_RUN : (fetch_fire && fault) ? IFC_HOLD : state;
  end
  // PC and state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_o <= RESET_PC;
      state <= IFC_BOOT;
    end else begin
      pc_o <= pc_nx;
      state <= state_nx;
    end
  if_fifo #(.W($bits(if_entry_t)), .D(QDEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(fetch_fire),
    .pop(deq),
    .flush(flush),
    .din(push_e),
    .dout(raw_e),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_if_ctrl.sv
// tb_if_ctrl: randomized bench against a queue-based fetch model
module tb_if_ctrl;
  logic clk = 0, rst_n = 0;
  logic [31:0] pc_o, if_bus_instr_i = 0, redirect_pc_i = 0, trap_pc_i = 0, id_pc_o, id_instr_o;
  logic if_bus_pc_misalign_i = 0, if_bus_bus_err_i = 0, redirect_valid_i = 0, trap_valid_i = 0;
  logic id_valid_o, id_ready_i = 0;
  logic [1:0] id_exc_o;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic [1:0] exc;} ent_t;
  ent_t q[$];
  logic [31:0] m_pc;
  bit m_boot, m_halt;
  always #5 clk = ~clk;
  if_ctrl #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .if_bus_instr_i(if_bus_instr_i),
    .if_bus_pc_misalign_i(if_bus_pc_misalign_i), .if_bus_bus_err_i(if_bus_bus_err_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o), .id_exc_o(id_exc_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction
  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 7))
      0: return 32'hFFFFFFFC;
      1: return {$urandom} | 32'(($urandom_range(1, 3)));
      2: return 32'h80;
      default: return {$urandom} & ~32'h3;
    endcase
  endfunction
  task automatic model_reset();
    q.delete();
    m_pc = 32'h0;
    m_boot = 1;
    m_halt = 0;
  endtask
  task automatic check_outputs();
    bit v;
    v = q.size() != 0;
    check("pc_o", pc_o, m_pc);
    check("id_valid", id_valid_o, v);
    check("id_pc", id_pc_o, v ? q[0].pc : 32'h0);
    check("id_instr", id_instr_o, v ? q[0].instr : 32'h0);
    check("id_exc", id_exc_o, v ? q[0].exc : 2'b00);
  endtask
  task automatic step();
    bit fl, dq, fire;
    logic [1:0] e;
    fl = trap_valid_i || redirect_valid_i;
    dq = q.size() != 0 && id_ready_i;
    fire = !m_boot && !m_halt && !fl && (q.size() < 2 || dq);
    e = {if_bus_bus_err_i, if_bus_pc_misalign_i || m_pc % 4 != 0};
    if (fl) begin
      q.delete();
      m_pc = trap_valid_i ? trap_pc_i : redirect_pc_i;
      m_halt = 0;
    end else begin
      if (dq) void'(q.pop_front());
      if (fire) begin
        q.push_back('{pc: m_pc, instr: if_bus_instr_i, exc: e});
        if (e != 0) m_halt = 1;
        else m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 0;
  endtask
  task automatic drive_random();
    int r;
    r = $urandom_range(0, 99);
    id_ready_i = $urandom_range(0, 2) != 0;
    trap_valid_i = r < 4 || r == 99;
    redirect_valid_i = (r >= 4 && r < 10) || r == 99;
    trap_pc_i = pick_target();
    redirect_pc_i = pick_target();
    if_bus_instr_i = word_at(m_pc);
    if_bus_pc_misalign_i = $urandom_range(0, 15) == 0;
    if_bus_bus_err_i = $urandom_range(0, 15) == 0;
  endtask
  task automatic drive_quiet();
    trap_valid_i = 0;
    redirect_valid_i = 0;
    if_bus_pc_misalign_i = 0;
    if_bus_bus_err_i = 0;
    if_bus_instr_i = word_at(m_pc);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;
    id_ready_i = 1;
    for (int c = 0; c < 6; c++) begin
      check_outputs();
      drive_quiet();
      step();
      @(negedge clk);
    end
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1;
      end
      check_outputs();
      drive_random();
      step();
      @(negedge clk);
    end
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_ctrl.md
Name: if_ctrl

Overview:
- Front-end controller wrapped around the combinational fetch bus.
- Owns the program counter and drives it to the fetch bus.
- Captures the returned instruction and its fault flags into a 2-entry fetch queue.
- Presents the queue head to decode with a valid/ready handshake; handles branch/jump redirects, trap redirects, backpressure and fault-hold.

Parameters:
- RESET_PC, 0 (`PC_WIDTH wide): PC loaded on reset.
- QDEPTH, 2: fetch queue depth. Only 2 is supported; 1-bit pointers.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pc_o  out  `PC_WIDTH  fetch address to fetch bus
- if_bus_instr_i  in  `INSTR_WIDTH  instruction returned for pc_o, same cycle
- if_bus_pc_misalign_i  in  1  fetch bus misalign flag
- if_bus_bus_err_i  in  1  fetch bus error flag
- redirect_valid_i  in  1  branch/jump redirect from execute
- redirect_pc_i  in  `PC_WIDTH  redirect target
- trap_valid_i  in  1  trap/exception redirect
- trap_pc_i  in  `PC_WIDTH  trap vector
- id_valid_o  out  1  queue head valid
- id_ready_i  in  1  decode accepts head
- id_pc_o  out  `PC_WIDTH  head PC
- id_instr_o  out  `INSTR_WIDTH  head instruction
- id_exc_o  out  `IF_EXC_WIDTH  head fault flags: bit0 misalign, bit1 bus error

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - pc_o = RESET_PC; state = BOOT.
  - Queue empty: count=0, rd_ptr=wr_ptr=0.
  - id_valid_o=0; id_pc_o, id_instr_o and id_exc_o = 0.
- Reset asserted mid-operation discards the queue and the PC immediately; no partial state survives.
- States:
  - BOOT: one cycle after reset release, no fetch. Goes to RUN.
  - RUN: fetching.
  - HOLD: a faulting entry has been pushed; no fetch.
- Fetch:
  - The fetch bus is combinational, so fetch completes in the cycle pc_o is presented.
  - fetch_fire = (state==RUN) && !flush && (count<2 || deq).
  - On fetch_fire, push {pc_o, if_bus_instr_i, exc} and set pc_o <= pc_o + 4.
  - The +4 wraps modulo 2^`PC_WIDTH; 0xFFFFFFFC goes to 0x0.
  - exc[0] = if_bus_pc_misalign_i | (pc_o[1:0] != 0); exc[1] = if_bus_bus_err_i.
- Fault hold:
  - If a pushed entry has a nonzero exc, state goes RUN -> HOLD the next cycle.
  - pc_o does not advance past the faulting PC.
- Dequeue:
  - deq = id_valid_o && id_ready_i; pops the head.
  - id_valid_o = (count != 0).
  - id_* outputs show the head entry and are 0 when empty.
  - Latency: an instruction fetched in cycle N is visible at id_* in cycle N+1 at the earliest.
- Simultaneous push and pop: count unchanged, both pointers advance. A full queue with deq in the same cycle still accepts a push.
- Redirect:
  - flush = trap_valid_i | redirect_valid_i.
  - On flush: the queue is emptied (count, rd_ptr, wr_ptr <= 0), there is no push, and any deq in the same cycle is ignored by the queue.
  - New pc_o is trap_pc_i if trap_valid_i, else redirect_pc_i; trap has priority.
  - State goes to RUN from any state, including BOOT and HOLD. Fetch from the new PC starts the cycle after the flush.
- Backpressure: with id_ready_i=0 and the queue full, pc_o holds and no push occurs.
- No combinational path from id_ready_i to pc_o. A combinational path from id_ready_i to the push enable is allowed.

Decomposition:
- Additions to defines.v:
  - `IF_EXC_WIDTH (2), `IF_EXC_MISALIGN (0), `IF_EXC_BUSERR (1).
  - State encodings `IFC_BOOT, `IFC_RUN, `IFC_HOLD (2 bits).
  - `PC_STEP (4).
- Sub-module if_fifo: 2-entry synchronous FIFO with push, pop and flush, full/empty/count outputs, and entry width as a parameter.
- if_ctrl holds the PC register, the state machine and the next-PC mux.

Test Plan:
- Boot: release rst_n with RESET_PC=0 and id_ready_i=1. Expect pc_o=0x0 for 2 cycles (BOOT, then first fetch), then 0x4, 0x8. id_valid_o rises the cycle after the first fetch with id_pc_o=0x0 and id_instr_o equal to the word at 0x0.
- Backpressure: id_ready_i=0 from boot. After two pushes count=2, pc_o holds 0x8 and id_pc_o=0x0. Raise id_ready_i for 1 cycle: pop 0x0 and push 0x8 in the same cycle; then pc_o=0xC and id_pc_o=0x4.
- Redirect: with the queue holding 0x4 and 0x8, pulse redirect_valid_i with redirect_pc_i=0x100 alongside id_ready_i=1. Next cycle id_valid_o=0 and pc_o=0x100; the cycle after, id_pc_o=0x100.
- Priority: trap_valid_i (0x80) and redirect_valid_i (0x200) asserted together -> next pc_o=0x80.
- Fault hold: redirect to 0x102 -> entry pushed with id_exc_o=2'b01, pc_o stays 0x102 and the state is HOLD. A later trap_valid_i to 0x40 resumes fetch at 0x40.
- Wrap: redirect to 0xFFFFFFFC -> next pc_o=0x0 with no fault flags.
